// File: rtl/popcount_accumulator.sv
// popcount_accumulator
// Sums WORDS consecutive per-word popcounts into a frame total, compares the
// total against THRESH (binarized-neuron fire) and presents the result through
// a valid/ready output handshake. Counts above 32 are clamped and flagged.

module popcount_accumulator #(
    parameter int CNT_W  = 6,
    parameter int WORDS  = 8,
    parameter int ACC_W  = 9,
    parameter int THRESH = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CNT_W-1:0] in_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_fire,
    output logic             err_sat
);

    // Word counter only needs to reach WORDS-1; the final accept wraps it to 0.
    localparam int              WC_W      = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(WORDS - 1);
    localparam logic [ACC_W:0]  THRESH_V  = (ACC_W + 1)'(THRESH);
    localparam logic [31:0]     MAX_COUNT = 32'd32;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t            r_state;
    logic [ACC_W-1:0]  r_acc;
    logic [WC_W-1:0]   r_word_cnt;
    logic              r_out_valid;
    logic [ACC_W-1:0]  r_out_sum;
    logic              r_out_fire;
    logic              r_err_sat;

    logic [31:0]       w_in_ext;
    logic              w_over;
    logic [ACC_W-1:0]  w_clamped;
    logic [ACC_W:0]    w_sum_wide;
    logic              w_fire;

    // Clamp the incoming count and form the running sum one bit wider than
    // the accumulator so the no-overflow property can be checked.
    always_comb begin
        w_in_ext   = 32'(in_count);
        w_over     = (w_in_ext > MAX_COUNT);
        w_clamped  = w_over ? ACC_W'(MAX_COUNT) : ACC_W'(w_in_ext);
        w_sum_wide = {1'b0, r_acc} + {1'b0, w_clamped};
        w_fire     = (w_sum_wide >= THRESH_V);
    end

    // clear has to block the input in the same cycle, so in_ready is the
    // state decode gated by clear rather than a pure register.
    assign in_ready  = (r_state == ACCUM) && !clear;
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_fire  = r_out_fire;
    assign err_sat   = r_err_sat;

    // Frame FSM: accumulate WORDS counts, then hold the result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ACCUM;
            r_acc       <= '0;
            r_word_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_fire  <= 1'b0;
            r_err_sat   <= 1'b0;
        end else if (clear) begin
            // err_sat and the last out_sum/out_fire survive a frame abort.
            r_state     <= ACCUM;
            r_acc       <= '0;
            r_word_cnt  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (in_valid) begin
                        assert (w_sum_wide[ACC_W] == 1'b0)
                            else $error("popcount_accumulator: accumulator overflow");
                        if (w_over) begin
                            r_err_sat <= 1'b1;
                        end
                        if (r_word_cnt == LAST_WORD) begin
                            r_out_sum   <= w_sum_wide[ACC_W-1:0];
                            r_out_fire  <= w_fire;
                            r_acc       <= '0;
                            r_word_cnt  <= '0;
                            r_out_valid <= 1'b1;
                            r_state     <= HOLD;
                        end else begin
                            r_acc      <= w_sum_wide[ACC_W-1:0];
                            r_word_cnt <= r_word_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ACCUM;
                    end
                end
                default: begin
                    r_state     <= ACCUM;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_popcount_accumulator.sv
// Self-checking bench for popcount_accumulator: directed frames from the test
// plan followed by random traffic, all checked against a frame-level model.

module tb_popcount_accumulator;

    localparam int CNT_W  = 6;
    localparam int WORDS  = 8;
    localparam int ACC_W  = 9;
    localparam int THRESH = 128;

    logic             clk;
    logic             rst_n;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [CNT_W-1:0] in_count;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_fire;
    logic             err_sat;

    int checks   = 0;
    int failures = 0;

    // Reference model: list of clamped counts in the open frame plus the
    // last completed frame result.
    int m_words[$];
    bit m_pending;
    int m_sum;
    int m_fire;
    int m_err;

    popcount_accumulator #(
        .CNT_W (CNT_W),
        .WORDS (WORDS),
        .ACC_W (ACC_W),
        .THRESH(THRESH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_count (in_count),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_fire (out_fire),
        .err_sat  (err_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_words.delete();
        m_pending = 1'b0;
        m_sum     = 0;
        m_fire    = 0;
        m_err     = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'(m_pending));
        check({tag, "_out_sum"},   32'(out_sum),   32'(m_sum));
        check({tag, "_out_fire"},  32'(out_fire),  32'(m_fire));
        check({tag, "_err_sat"},   32'(err_sat),   32'(m_err));
    endtask

    // One clock: drive at negedge, check in_ready, advance model, check
    // registered outputs just after the rising edge.
    task automatic cycle(input bit v, input int cnt, input bit ordy, input bit clr, input string tag);
        int total;
        @(negedge clk);
        in_valid  = v;
        in_count  = CNT_W'(cnt);
        out_ready = ordy;
        clear     = clr;
        #1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'(!m_pending && !clr));
        if (clr) begin
            m_words.delete();
            m_pending = 1'b0;
        end else if (!m_pending && v) begin
            if (cnt > 32) m_err = 1;
            m_words.push_back((cnt > 32) ? 32 : cnt);
            if (m_words.size() == WORDS) begin
                total = 0;
                foreach (m_words[k]) total += m_words[k];
                m_sum     = total;
                m_fire    = (total >= THRESH) ? 1 : 0;
                m_pending = 1'b1;
                m_words.delete();
            end
        end else if (m_pending && ordy) begin
            m_pending = 1'b0;
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic frame(input int cnt, input bit ordy, input string tag);
        for (int i = 0; i < WORDS; i++) cycle(1'b1, cnt, ordy, 1'b0, tag);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset(input string tag);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clear     = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs(tag);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_count  = '0;
        out_ready = 1'b0;
        model_reset();
        #12;
        check_outputs("reset");
        check("reset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Equal words exactly at threshold, consumer always ready.
        frame(16, 1'b1, "thr");
        check("thr_sum", 32'(out_sum), 32'd128);
        check("thr_fire", 32'(out_fire), 32'd1);
        cycle(1'b0, 0, 1'b1, 1'b0, "thr_take");
        cycle(1'b0, 0, 1'b1, 1'b0, "thr_ready_back");

        // Just below threshold.
        frame(15, 1'b1, "below");
        check("below_sum", 32'(out_sum), 32'd120);
        check("below_fire", 32'(out_fire), 32'd0);
        cycle(1'b0, 0, 1'b1, 1'b0, "below_take");

        // Maximum counts with ten cycles of backpressure; inputs keep coming.
        frame(32, 1'b0, "max");
        check("max_sum", 32'(out_sum), 32'd256);
        for (int i = 0; i < 10; i++) cycle(1'b1, 7, 1'b0, 1'b0, "max_hold");
        check("max_sum_held", 32'(out_sum), 32'd256);
        cycle(1'b1, 7, 1'b1, 1'b0, "max_take");
        cycle(1'b0, 0, 1'b0, 1'b0, "max_accum");

        // Out-of-range count is clamped and flagged stickily.
        cycle(1'b1, 40, 1'b1, 1'b0, "sat_first");
        for (int i = 1; i < WORDS; i++) cycle(1'b1, 0, 1'b1, 1'b0, "sat_rest");
        check("sat_sum", 32'(out_sum), 32'd32);
        check("sat_err", 32'(err_sat), 32'd1);
        cycle(1'b0, 0, 1'b0, 1'b1, "sat_clear");
        check("sat_err_after_clear", 32'(err_sat), 32'd1);

        // Reset in the middle of a frame.
        for (int i = 0; i < 5; i++) cycle(1'b1, 20, 1'b1, 1'b0, "mid");
        async_reset("mid_reset");
        check("mid_reset_err", 32'(err_sat), 32'd0);
        frame(1, 1'b1, "after_reset");
        check("after_reset_sum", 32'(out_sum), 32'd8);
        check("after_reset_fire", 32'(out_fire), 32'd0);
        cycle(1'b0, 0, 1'b1, 1'b0, "after_reset_take");

        // Clear colliding with an input, then clear while holding a frame.
        for (int i = 0; i < 3; i++) cycle(1'b1, 10, 1'b1, 1'b0, "coll");
        cycle(1'b1, 10, 1'b1, 1'b1, "coll_clear");
        frame(10, 1'b0, "coll_frame");
        check("coll_frame_sum", 32'(out_sum), 32'd80);
        cycle(1'b0, 0, 1'b1, 1'b1, "hold_clear");
        check("hold_clear_valid", 32'(out_valid), 32'd0);
        frame(10, 1'b1, "coll_next");
        check("coll_next_sum", 32'(out_sum), 32'd80);
        cycle(1'b0, 0, 1'b1, 1'b0, "coll_next_take");

        // Random traffic with occasional clears and overrange counts.
        for (int i = 0; i < 400; i++) begin
            bit v, o, c;
            int n;
            v = ($urandom_range(0, 9) < 7);
            o = ($urandom_range(0, 1) == 1);
            c = ($urandom_range(0, 39) == 0);
            n = ($urandom_range(0, 9) == 0) ? $urandom_range(33, 63) : $urandom_range(0, 32);
            cycle(v, n, o, c, "rand");
        end

        async_reset("final_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/popcount_accumulator.md
Name: popcount_accumulator

Overview:
- Sequential stage directly downstream of the 32-input population counter.
- Accepts one per-word popcount (0..32) per handshake and sums WORDS consecutive counts into one frame total.
- Compares the total against a threshold, as a binarized-neuron activation does.
- Presents the frame sum and fire bit through a valid/ready output handshake.

Parameters:
- CNT_W, 6, width of the incoming per-word count; legal values 0..32.
- WORDS, 8, number of counts per frame; legal range 2..64.
- ACC_W, 9, accumulator/sum width; must hold WORDS*32 (256 at default).
- THRESH, 128, fire threshold; out_fire = (sum >= THRESH).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- clear  input  1  synchronous frame abort (active-high).
- in_valid  input  1  in_count is valid this cycle.
- in_ready  output  1  block accepts in_count this cycle.
- in_count  input  CNT_W  per-word popcount from the counter stage.
- out_valid  output  1  out_sum/out_fire hold a completed frame.
- out_ready  input  1  downstream accepts the frame this cycle.
- out_sum  output  ACC_W  frame total.
- out_fire  output  1  out_sum >= THRESH.
- err_sat  output  1  sticky flag: an in_count > 32 was accepted.

Behaviour:
- Reset (rst_n=0, async) forces the following. Deassertion of rst_n is synchronised externally.
  - state=ACCUM, acc=0, word_cnt=0.
  - out_valid=0, out_sum=0, out_fire=0, err_sat=0.
  - in_ready=1 on the first cycle after reset release.
- Input accept: in_valid & in_ready at a rising clk edge.
- Output accept: out_valid & out_ready at a rising clk edge.
- FSM has 2 states, ACCUM and HOLD.
- ACCUM:
  - in_ready=1, out_valid=0.
  - On input accept: acc += clamp(in_count), word_cnt += 1.
  - clamp(x) = 32 if x > 32, else x. A clamped accept sets err_sat=1.
  - On the accept that makes word_cnt reach WORDS:
    - out_sum <= acc + clamp(in_count).
    - out_fire <= (that sum >= THRESH).
    - acc <= 0, word_cnt <= 0, state <= HOLD.
  - out_valid rises the cycle after the last accept, giving 1-cycle latency from the final word to out_valid.
- HOLD:
  - in_ready=0, out_valid=1.
  - out_sum and out_fire are stable until the output accept.
  - On output accept: state <= ACCUM, out_valid <= 0.
  - out_sum and out_fire keep their last value after the output accept.
  - in_ready returns the cycle after the output accept. This costs at least 1 bubble cycle per frame, which is accepted.
- in_valid=0 in ACCUM: no change. Gaps between words are allowed and arbitrary in length.
- out_ready=0 in HOLD: hold indefinitely; no input is accepted, so nothing is lost.
- clear=1 (synchronous, priority over all handshakes in the same cycle):
  - acc <= 0, word_cnt <= 0, state <= ACCUM, out_valid <= 0.
  - Any pending frame is discarded.
  - An input presented the same cycle is not accepted; in_ready is forced to 0 while clear=1.
  - err_sat is not cleared by clear; only rst_n clears it.
- Arithmetic:
  - acc is unsigned ACC_W.
  - With legal WORDS and clamping, overflow cannot occur. No wrap logic is required.
  - The overflow bound is asserted in simulation.
- Reset mid-frame: the partial sum is lost and no out_valid is produced for the aborted frame.
- All outputs are registered; there is no combinational path from inputs to outputs except through in_ready/out_valid state decode.

Test Plan:
- Equal words at threshold: WORDS=8, eight accepts of in_count=16, out_ready=1 -> out_valid one cycle after 8th accept, out_sum=128, out_fire=1, then in_ready=1 next cycle.
- Just below threshold: eight accepts of in_count=15 -> out_sum=120, out_fire=0.
- Maximum counts and backpressure: eight accepts of 32 with out_ready=0 for 10 cycles -> out_sum=256 (no overflow), in_ready=0 and outputs stable for all 10 cycles; single output accept then ACCUM.
- Out-of-range input: one accept of in_count=40 plus seven of 0 -> out_sum=32, err_sat=1; err_sat stays 1 after clear, returns 0 only on rst_n.
- Reset mid-frame: accept 5 words of 20, pulse rst_n low asynchronously between edges -> outputs 0 immediately. Then 8 words of 1 -> out_sum=8, out_fire=0.
- Clear collision: clear=1 together with in_valid=1 on 4th word, also clear=1 while in HOLD -> word not accepted, pending frame dropped (out_valid=0 next cycle). Next 8 words of 10 -> out_sum=80.
